// File: rtl/beat_decoder_if.sv
// Bus bundle for beat_decoder: the incoming beat line plus the decoded rate,
// lock, beat and error indications.
interface beat_decoder_if;
   logic       pulse;
   logic [2:0] S;
   logic       locked;
   logic       beat;
   logic       error;

   modport master (output pulse, input S, locked, beat, error);
   modport slave  (input pulse, output S, locked, beat, error);
endinterface

// File: rtl/beat_decoder.sv
// Recovers the 3-bit rate code from a beat line by timing rising-edge intervals.
// Define BEAT_DECODER_TOL_EN to accept intervals within +/-1 cycle of a period.
module beat_decoder #(
   parameter int unsigned TIMEOUT    = 200,
   parameter int unsigned LOCK_COUNT = 2
) (
   input  logic          clk,
   input  logic          reset,
   beat_decoder_if.slave bus
);

   typedef enum logic [1:0] {IDLE, FIRST, CAND, LOCKED} state_t;

   localparam logic [7:0] TO_CNT   = 8'(TIMEOUT);
   localparam logic [2:0] LOCK_N   = 3'(LOCK_COUNT);
   localparam logic       LOCK_ONE = (LOCK_COUNT == 1);

   state_t     state_q;
   logic       pulse_q;
   logic [7:0] cnt_q, cnt_d;
   logic [2:0] cand_q, mcnt_q, s_q;
   logic       beat_q, error_q;

   logic       rise, timeout, hit;
   logic [2:0] k, mcnt_inc;

   function automatic logic [7:0] period_of(input logic [2:0] code);
      case (code)
         3'd0: return 8'd100;
         3'd1: return 8'd66;
         3'd2: return 8'd50;
         3'd3: return 8'd40;
         3'd4: return 8'd30;
         3'd5: return 8'd20;
         3'd6: return 8'd12;
         3'd7: return 8'd6;
         default: return 8'd0;
      endcase
   endfunction

   function automatic logic in_window(input logic [7:0] c, input logic [7:0] p);
`ifdef BEAT_DECODER_TOL_EN
      return (c == p) || (c == p - 8'd1) || (c == p + 8'd1);
`else
      return (c == p);
`endif
   endfunction

   assign rise     = bus.pulse & ~pulse_q;
   assign timeout  = (cnt_q == TO_CNT) && !rise;
   assign mcnt_inc = mcnt_q + 3'd1;

   // Periods (and their tolerance windows) never overlap, so at most one code hits.
   always_comb begin
      hit = 1'b0;
      k   = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (in_window(cnt_q, period_of(3'(i)))) begin
            hit = 1'b1;
            k   = 3'(i);
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (rise)
         cnt_d = 8'd1;
      else if (cnt_q != 8'd0 && cnt_q != 8'hFF)
         cnt_d = cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         pulse_q <= 1'b0;
         cnt_q   <= 8'd0;
         cand_q  <= 3'd0;
         mcnt_q  <= 3'd0;
         s_q     <= 3'd0;
         beat_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         pulse_q <= bus.pulse;
         cnt_q   <= cnt_d;
         beat_q  <= 1'b0;
         error_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (rise)
                  state_q <= FIRST;
            end
            FIRST: begin
               if (rise && hit) begin
                  cand_q <= k;
                  mcnt_q <= 3'd1;
                  if (LOCK_ONE) begin
                     state_q <= LOCKED;
                     s_q     <= k;
                  end else begin
                     state_q <= CAND;
                  end
               end else if (rise) begin
                  error_q <= 1'b1;
               end else if (timeout) begin
                  state_q <= IDLE;
               end
            end
            CAND: begin
               if (rise && hit && k == cand_q) begin
                  mcnt_q <= mcnt_inc;
                  if (mcnt_inc >= LOCK_N) begin
                     state_q <= LOCKED;
                     s_q     <= cand_q;
                  end
               end else if (rise && hit) begin
                  cand_q <= k;
                  mcnt_q <= 3'd1;
               end else if (rise) begin
                  error_q <= 1'b1;
                  state_q <= FIRST;
               end else if (timeout) begin
                  state_q <= IDLE;
               end
            end
            LOCKED: begin
               if (rise && hit && k == s_q) begin
                  beat_q <= 1'b1;
               end else if (rise && hit) begin
                  state_q <= CAND;
                  cand_q  <= k;
                  mcnt_q  <= 3'd1;
               end else if (rise) begin
                  error_q <= 1'b1;
                  state_q <= FIRST;
               end else if (timeout) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.S      = s_q;
   assign bus.locked = (state_q == LOCKED);
   assign bus.beat   = beat_q;
   assign bus.error  = error_q;

endmodule

// File: tb/tb_beat_decoder.sv
// Self-checking bench for beat_decoder: directed scenarios plus random interval
// streams, compared cycle by cycle against a rule-level reference model.
module tb_beat_decoder;
   localparam int TIMEOUT    = 200;
   localparam int LOCK_COUNT = 2;
   localparam int PER [8]    = '{100, 66, 50, 40, 30, 20, 12, 6};
   localparam int M_IDLE = 0, M_FIRST = 1, M_CAND = 2, M_LOCKED = 3;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   beat_decoder_if bus ();

   beat_decoder #(.TIMEOUT(TIMEOUT), .LOCK_COUNT(LOCK_COUNT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int rises[$];
   int wid   = 1;

   // Reference model state: rule-level, interval measured from absolute cycle numbers.
   int         m_cyc = 0, m_last = -1, m_state = M_IDLE, m_cand = 0, m_mcnt = 0;
   logic       m_prev = 1'b0;
   logic [2:0] m_S = 3'd0;
   logic       m_locked = 1'b0, m_beat = 1'b0, m_err = 1'b0;

   logic [5:0] dut_o, mdl_o;
   assign dut_o = {bus.S, bus.locked, bus.beat, bus.error};
   assign mdl_o = {m_S, m_locked, m_beat, m_err};

   function automatic int code_of(input int iv);
      code_of = -1;
      for (int c = 0; c < 8; c++) begin
`ifdef BEAT_DECODER_TOL_EN
         if (iv >= PER[c] - 1 && iv <= PER[c] + 1) code_of = c;
`else
         if (iv == PER[c]) code_of = c;
`endif
      end
   endfunction

   function automatic logic high_at(input int i);
      foreach (rises[j])
         if (i >= rises[j] && i < rises[j] + wid) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      m_last = -1; m_state = M_IDLE; m_cand = 0; m_mcnt = 0; m_prev = 1'b0;
      m_S = 3'd0; m_locked = 1'b0; m_beat = 1'b0; m_err = 1'b0;
   endtask

   task automatic model_step(input logic p);
      int   iv, k;
      logic r;
      r      = p & ~m_prev;
      m_prev = p;
      iv     = (m_last < 0) ? 0 : (m_cyc - m_last);
      if (iv > 255) iv = 255;
      k      = code_of(iv);
      m_beat = 1'b0;
      m_err  = 1'b0;
      if (r) begin
         m_last = m_cyc;
         if (m_state == M_IDLE) m_state = M_FIRST;
         else if (k < 0) begin m_err = 1'b1; m_state = M_FIRST; end
         else if (m_state == M_LOCKED && k == int'(m_S)) m_beat = 1'b1;
         else if (m_state == M_CAND && k == m_cand) begin
            m_mcnt++;
            if (m_mcnt >= LOCK_COUNT) begin m_state = M_LOCKED; m_S = 3'(m_cand); end
         end else begin
            m_cand = k;
            m_mcnt = 1;
            if (m_state == M_FIRST && LOCK_COUNT == 1) begin m_state = M_LOCKED; m_S = 3'(k); end
            else m_state = M_CAND;
         end
      end else if (iv == TIMEOUT) begin
         m_state = M_IDLE;
      end
      m_cyc++;
      m_locked = (m_state == M_LOCKED);
   endtask

   task automatic tick(input logic p);
      bus.pulse = p;
      @(posedge clk);
      model_step(p);
      #1;
   endtask

   task automatic do_reset();
      bus.pulse = 1'b0;
      reset     = 1'b0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #3;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (dut_o !== 6'b0) begin bad++; $display("FAIL reset_state got=%b want=%b", dut_o, 6'b0); end
      for (int i = 0; i < 5; i++) begin
         tick(1'b0);
         total++;
         if (dut_o !== 6'b0) begin bad++; $display("FAIL reset_idle cyc=%0d got=%b want=%b", i, dut_o, 6'b0); end
      end
   endtask

   task automatic test_period50();
      int nb = 0, ne = 0;
      do_reset();
      wid   = $urandom_range(1, 3);
      rises = '{0, 50, 100, 150, 200};
      for (int i = 0; i <= 210; i++) begin
         tick(high_at(i));
         total++;
         if (dut_o !== mdl_o) begin bad++; $display("FAIL p50 cyc=%0d got=%b want=%b", i, dut_o, mdl_o); end
         if (bus.beat) nb++;
         if (bus.error) ne++;
         if (i == 99) begin
            total++;
            if (bus.locked !== 1'b0) begin bad++; $display("FAIL p50_prelock got=%b want=0", bus.locked); end
         end
         if (i == 100) begin
            total++;
            if ({bus.locked, bus.S} !== 4'b1_010) begin bad++; $display("FAIL p50_lock got=%b want=%b", {bus.locked, bus.S}, 4'b1_010); end
         end
      end
      total++;
      if (nb != 2 || ne != 0) begin bad++; $display("FAIL p50_counts beats=%0d errors=%0d want 2/0", nb, ne); end
   endtask

   task automatic test_switch();
      do_reset();
      wid   = $urandom_range(1, 3);
      rises = '{0, 50, 100, 120, 140, 160};
      for (int i = 0; i <= 170; i++) begin
         tick(high_at(i));
         total++;
         if (dut_o !== mdl_o) begin bad++; $display("FAIL switch cyc=%0d got=%b want=%b", i, dut_o, mdl_o); end
         if (i == 120) begin
            total++;
            if (bus.locked !== 1'b0) begin bad++; $display("FAIL switch_drop got=%b want=0", bus.locked); end
         end
         if (i == 140) begin
            total++;
            if ({bus.locked, bus.S} !== 4'b1_101) begin bad++; $display("FAIL switch_relock got=%b want=%b", {bus.locked, bus.S}, 4'b1_101); end
         end
         if (i == 160) begin
            total++;
            if (bus.beat !== 1'b1) begin bad++; $display("FAIL switch_beat got=%b want=1", bus.beat); end
         end
      end
   endtask

   task automatic test_error_recover();
      do_reset();
      wid   = $urandom_range(1, 3);
      rises = '{0, 30, 60, 105, 135, 165};
      for (int i = 0; i <= 175; i++) begin
         tick(high_at(i));
         total++;
         if (dut_o !== mdl_o) begin bad++; $display("FAIL errrec cyc=%0d got=%b want=%b", i, dut_o, mdl_o); end
         if (i == 105) begin
            total++;
            if ({bus.error, bus.locked, bus.beat} !== 3'b100) begin bad++; $display("FAIL errrec_strobe got=%b want=100", {bus.error, bus.locked, bus.beat}); end
         end
         if (i == 106) begin
            total++;
            if (bus.error !== 1'b0) begin bad++; $display("FAIL errrec_oneshot got=%b want=0", bus.error); end
         end
         if (i == 165) begin
            total++;
            if ({bus.locked, bus.S} !== 4'b1_100) begin bad++; $display("FAIL errrec_relock got=%b want=%b", {bus.locked, bus.S}, 4'b1_100); end
         end
      end
   endtask

   task automatic test_timeout();
      do_reset();
      wid   = $urandom_range(1, 3);
      rises = '{0, 100, 200};
      for (int i = 0; i <= 200 + 260; i++) begin
         tick(high_at(i));
         total++;
         if (dut_o !== mdl_o) begin bad++; $display("FAIL tmo cyc=%0d got=%b want=%b", i, dut_o, mdl_o); end
         if (i == 200 + TIMEOUT - 1) begin
            total++;
            if (bus.locked !== 1'b1) begin bad++; $display("FAIL tmo_still_locked got=%b want=1", bus.locked); end
         end
         if (i == 200 + TIMEOUT) begin
            total++;
            if (bus.locked !== 1'b0) begin bad++; $display("FAIL tmo_unlock got=%b want=0", bus.locked); end
         end
      end
      total++;
      if (bus.S !== 3'b000 || dut.cnt_q !== 8'd255) begin
         bad++; $display("FAIL tmo_hold S=%b cnt=%0d want S=000 cnt=255", bus.S, dut.cnt_q);
      end
   endtask

   task automatic test_period51();
      int ne = 0, nl = 0;
      do_reset();
      wid   = 1;
      rises = '{0, 51, 102, 153, 204};
      for (int i = 0; i <= 210; i++) begin
         tick(high_at(i));
         total++;
         if (dut_o !== mdl_o) begin bad++; $display("FAIL p51 cyc=%0d got=%b want=%b", i, dut_o, mdl_o); end
         if (bus.error) ne++;
         if (bus.locked) nl++;
      end
      total++;
`ifdef BEAT_DECODER_TOL_EN
      if ({bus.locked, bus.S} !== 4'b1_010 || ne != 0) begin bad++; $display("FAIL p51_tol locked/S=%b errors=%0d want 1010/0", {bus.locked, bus.S}, ne); end
`else
      if (nl != 0 || ne != 4) begin bad++; $display("FAIL p51_exact lockedcycles=%0d errors=%0d want 0/4", nl, ne); end
`endif
   endtask

   task automatic test_async_reset();
      do_reset();
      wid   = 1;
      rises = '{0, 6, 12, 18, 24};
      for (int i = 0; i <= 25; i++) begin
         tick(high_at(i));
         total++;
         if (dut_o !== mdl_o) begin bad++; $display("FAIL arst_pre cyc=%0d got=%b want=%b", i, dut_o, mdl_o); end
      end
      total++;
      if ({bus.locked, bus.S} !== 4'b1_111) begin bad++; $display("FAIL arst_prelock got=%b want=%b", {bus.locked, bus.S}, 4'b1_111); end
      #2;
      reset     = 1'b0;
      bus.pulse = 1'b1;
      #1;
      total++;
      if (dut_o !== 6'b0) begin bad++; $display("FAIL arst_immediate got=%b want=%b", dut_o, 6'b0); end
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #3;
      reset = 1'b1;
      wid   = 2;
      rises = '{0, 6, 12, 18};
      for (int i = 0; i <= 20; i++) begin
         tick(high_at(i));
         total++;
         if (dut_o !== mdl_o) begin bad++; $display("FAIL arst_post cyc=%0d got=%b want=%b", i, dut_o, mdl_o); end
         if (i == 11) begin
            total++;
            if (bus.locked !== 1'b0) begin bad++; $display("FAIL arst_early got=%b want=0", bus.locked); end
         end
         if (i == 12) begin
            total++;
            if ({bus.locked, bus.S} !== 4'b1_111) begin bad++; $display("FAIL arst_relock got=%b want=%b", {bus.locked, bus.S}, 4'b1_111); end
         end
      end
   endtask

   task automatic test_random();
      int t, iv, sel, last;
      do_reset();
      wid = $urandom_range(1, 3);
      rises.delete();
      t = 0;
      rises.push_back(0);
      for (int n = 0; n < 60; n++) begin
         sel = $urandom_range(0, 9);
         if (sel < 7) begin
            iv = PER[$urandom_range(0, 7)];
`ifdef BEAT_DECODER_TOL_EN
            iv = iv + int'($urandom_range(0, 2)) - 1;
`endif
         end else if (sel < 9) begin
            iv = $urandom_range(7, 120);
         end else begin
            iv = TIMEOUT + $urandom_range(1, 60);
         end
         t += iv;
         rises.push_back(t);
      end
      last = t + 10;
      for (int i = 0; i <= last; i++) begin
         tick(high_at(i));
         total++;
         if (dut_o !== mdl_o) begin bad++; $display("FAIL rand cyc=%0d got=%b want=%b", i, dut_o, mdl_o); end
         total++;
         if ((bus.beat && !bus.locked) || (bus.beat && bus.error)) begin
            bad++; $display("FAIL rand_excl cyc=%0d beat=%b locked=%b error=%b want no beat w/o lock or with error", i, bus.beat, bus.locked, bus.error);
         end
      end
   endtask

   initial begin
      test_reset();
      test_period50();
      test_switch();
      test_error_recover();
      test_timeout();
      test_period51();
      test_async_reset();
      test_random();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/beat_decoder.md
# beat_decoder

Receive-side counterpart of the beat generator. Watches a single-clock-domain pulse stream, measures the interval between rising edges, and decodes it back to the 3-bit rate code that produced it. Reports a locked indication, the recovered code, a per-beat strobe and an error strobe. Used for loopback checking of the beat generator and for driving rate-dependent logic from an external beat line.

## Interface

Parameters:
- TIMEOUT, 200, cycles without a rising edge before tracking is abandoned; legal range 101..255.
- LOCK_COUNT, 2, consecutive matching intervals required to assert locked; legal range 1..7.

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-low; 0 clears all state immediately
- pulse  input  1  beat stream, synchronous to clk
- S  output  3  recovered rate code; reset 3'b000
- locked  output  1  high while the decoded rate is stable; reset 0
- beat  output  1  one-cycle strobe per matching edge while locked; reset 0
- error  output  1  one-cycle strobe on an interval matching no code; reset 0

## Operation

- Code table (code -> period in cycles): 000->100, 001->66, 010->50, 011->40, 100->30, 101->20, 110->12, 111->6.
- Edge detect: pulse_q registers pulse; rise = pulse & ~pulse_q. A level held high counts as one edge.
- Interval counter cnt[7:0], reset 0. On rise, cnt <= 1. Otherwise, if cnt != 0 and cnt != 255, cnt <= cnt + 1. At a rise, cnt equals the cycles since the previous rise.
- Match: cnt equals a table period; the matched code is k. All periods are distinct.
- Timeout: cnt == TIMEOUT with no rise in the same cycle.
- FSM states: IDLE, FIRST, CAND, LOCKED. Reset state is IDLE.
  - IDLE: on rise -> FIRST.
  - FIRST: rise+match -> CAND, cand=k, mcnt=1. rise+no match -> FIRST, error. timeout -> IDLE.
  - CAND: rise+match with k==cand -> mcnt+1; if the new mcnt==LOCK_COUNT -> LOCKED, S<=cand. rise+match with k!=cand -> CAND, cand=k, mcnt=1. rise+no match -> FIRST, error. timeout -> IDLE.
  - LOCKED: rise+match with k==S -> LOCKED, beat. rise+match with k!=S -> CAND, cand=k, mcnt=1. rise+no match -> FIRST, error. timeout -> IDLE.
- If LOCK_COUNT==1, FIRST goes directly to LOCKED on its first match.
- locked = (state==LOCKED). S changes only on entry to LOCKED and holds its last value otherwise.
- Simultaneous rise and timeout: the rise wins.
- Reset asserted mid-operation: all registers, including pulse_q, clear asynchronously. The first rise after release is treated as a fresh edge.

## Timing

- beat, error, locked and S are registered. Each updates at the clock edge that samples the deciding rise, so it is visible the cycle after that rise.
- Lock latency from IDLE is (LOCK_COUNT+1) rises. For code 111 with rises at cycles 0, 6, 12, locked is high from cycle 13.
- Unlock on timeout: locked is low from cycle lastrise+TIMEOUT+1.
- beat is never high while locked is low. beat and error are never high together.

## Configuration

- BEAT_DECODER_TOL_EN defined: a match also accepts cnt == period±1. Adjacent windows (6/12, 12/20, ...) do not overlap, so k stays unique.
- Not defined: only exact period equality matches.

## Test plan

- Period-50 stream from reset, LOCK_COUNT=2 -> locked rises the cycle after the 3rd rise, S=3'b010, beat every 50 cycles, error never asserts.
- Locked at period 50, then switch to period 20 -> locked drops the cycle after the first 20-cycle interval. After the second 20-cycle interval locked reasserts with S=3'b101.
- Single 45-cycle interval while locked at 30 -> one-cycle error, locked low, state FIRST. The next two 30-cycle intervals restore locked with S=3'b100.
- Pulses stop while locked at period 100 -> locked low exactly 201 cycles after the last rise, S held at 3'b000. cnt saturates at 255.
- Period-51 stream -> with BEAT_DECODER_TOL_EN: locked, S=3'b010. Without it: an error strobe on every interval and never locked.
- reset driven low mid-lock, between clock edges -> S=0, locked=0, beat=0, error=0 immediately. After release, a period-6 stream locks again after 3 rises.
